alu_mdu: RTL and testbench
==========================

# alu_mdu

Parametrised accumulator ALU for the SRP16 datapath and its wider derivatives. It keeps the single-accumulator, operand-bus programming model: carry, comparison flag, `write`/`writeu` loads and a tri-state read-out. It adds a WIDTH parameter, an explicit issue strobe, true signed compares, saturating shift amounts, and an iterative multiply/divide unit with a busy handshake and an extension register.

## Interface
- WIDTH, 16, datapath width; must be at least 8.
- UPPER_BITS, 4, number of accumulator MSBs loaded by `writeu`; must be less than WIDTH.
- clk  in  1  system clock; everything updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  5  operation code, sampled only when `valid`=1.
- valid  in  1  issues `opcode` on this edge.
- operand  in  WIDTH  operand bus, shared by ops and loads.
- write  in  1  loads acc ← operand.
- writeu  in  1  loads acc[WIDTH-1 -: UPPER_BITS] ← operand[UPPER_BITS-1:0].
- read  in  1  enables `accout`.
- accout  out  WIDTH  acc when `read`=1, otherwise high-Z.
- ext  out  WIDTH  extension register: product high half or remainder.
- carry  out  1  carry/borrow flag.
- flag  out  1  condition flag.
- busy  out  1  a MUL/DIV is in progress.

## Operation
Opcodes:
- 00 NOP, 01 ADD, 02 SUB, 03 SLA, 04 SRA, 05 SLL, 06 SRL, 07 AND, 08 OR, 09 XOR.
- 0A CL, 0B CG, 0C CE, 0D ADC, 0E SBB, 10 NOTF, 11 MUL, 12 DIV.
- All other codes behave as NOP.

Arithmetic:
- ADD/ADC: {carry, acc} ← acc + operand (+ carry for ADC), computed WIDTH+1 wide.
- SUB/SBB: acc ← acc − operand (− carry for SBB); carry ← borrow out (1 when the unsigned result is negative).

Shifts and logic:
- Shift amount is the full unsigned `operand`.
- For amounts ≥ WIDTH: SLL, SLA and SRL give 0; SRA gives all copies of the sign bit.
- Shifts and logic ops clear carry.

Compares and flag:
- CL and CG are true signed two's-complement compares; CE tests equality.
- Compares write only `flag`; acc and carry are unchanged.
- NOTF: flag ← ~flag.

MUL:
- Unsigned shift-add, one bit per cycle.
- {ext, acc} ← acc × operand.
- flag ← (ext ≠ 0), i.e. overflow; carry ← 0.

DIV:
- Unsigned restoring divide, one bit per cycle.
- acc ← quotient, ext ← remainder, flag ← 0, carry ← 0.
- Divide by zero: acc ← all ones, ext ← the original dividend, flag ← 1.
- The operand is latched at issue.

Same-edge priority, when not busy:
- An issued accumulator-writing op overrides `write`/`writeu`.
- Otherwise `writeu` overrides `write` on the upper UPPER_BITS; `write` still loads the remaining low bits.
- Compares, NOTF and NOP do not block loads.

State machine:
- IDLE → RUN on an issued MUL/DIV; this loads the counter with WIDTH.
- RUN decrements the counter each edge.
- RUN → IDLE on the edge where the counter reaches 0; the result is written on that edge.

While busy:
- `valid`, `write` and `writeu` are ignored; their effects are dropped, not queued.
- `read` and `accout` still work and show the unfinished partial value.

Reset:
- acc, ext, carry, flag, busy and the counter all go to 0 immediately.
- Reset aborts any MUL/DIV in progress.

## Timing
- Single-cycle ops and loads: result is visible after the issuing edge.
- MUL/DIV:
  - Issue edge E0 sets busy=1.
  - busy stays high for exactly WIDTH cycles and falls at edge E_WIDTH.
  - acc, ext and flag become final at E_WIDTH.
  - A new op can be issued on the edge after E_WIDTH, i.e. the first edge at which busy=0.
- `accout` is combinational from `read` and acc; no registering.
- Outputs after reset deassertion are all 0, with `accout` high-Z until `read` is asserted.

## Test plan
- ADD, WIDTH=16: acc=FFFF, ADD 0001 → acc=0000, carry=1. Then ADC 0000 → acc=0001, carry=0. Then SUB 0002 → acc=FFFF, carry=1.
- MUL: acc=1234, MUL 0100 → busy high for 16 cycles, then acc=3400, ext=0012, flag=1. A `write` of 5555 during busy → acc still 3400 at completion.
- DIV: acc=0064, DIV 0007 → acc=000E, ext=0002, flag=0. acc=0064, DIV 0000 → acc=FFFF, ext=0064, flag=1.
- Compares and NOTF: acc=8000, CL 0001 → flag=1. CG 0001 → flag=0. NOTF → flag=1. acc=7FFF, CE 7FFF → flag=1.
- Shifts and loads:
  - acc=8000, SRA 0014 → FFFF. Reload 8000, SRL 0010 → 0000.
  - `write`=1 and `writeu`=1 on the same edge with operand 1234 → acc=4234.
- Reset mid-operation: rst asserted mid-clock during cycle 5 of a MUL → busy, acc and flag are 0 before the next edge. After release, ADD 0003 → acc=0003.

Source files
------------

// File: rtl/alu_mdu_if.sv
// Operand/control bus and status outputs of the alu_mdu accumulator ALU.
// The master drives the opcode, the operand and the load/read strobes; the
// slave (the ALU) returns the extension register and the status flags.
interface alu_mdu_if #(
    parameter int WIDTH = 16
);
    logic [4:0]       opcode;
    logic             valid;
    logic [WIDTH-1:0] operand;
    logic             write;
    logic             writeu;
    logic             read;
    logic [WIDTH-1:0] ext;
    logic             carry;
    logic             flag;
    logic             busy;

    modport master (
        output opcode, valid, operand, write, writeu, read,
        input  ext, carry, flag, busy
    );

    modport slave (
        input  opcode, valid, operand, write, writeu, read,
        output ext, carry, flag, busy
    );
endinterface

// File: rtl/alu_mdu.sv
// Single-accumulator ALU with carry/flag, accumulator loads, a tri-state
// read-out and an iterative one-bit-per-cycle multiply/divide unit.
// The MUL/DIV datapath works in place on {ext, acc}, so the partial value is
// visible on accout while busy.
module alu_mdu #(
    parameter int WIDTH      = 16,
    parameter int UPPER_BITS = 4
) (
    input  logic            clk,
    input  logic            rst,
    alu_mdu_if.slave        bus,
    // Tri-state pin kept outside the interface so the bus bundle stays 2-state.
    output wire [WIDTH-1:0] accout
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [4:0] OP_ADD  = 5'h01;
    localparam logic [4:0] OP_SUB  = 5'h02;
    localparam logic [4:0] OP_SLA  = 5'h03;
    localparam logic [4:0] OP_SRA  = 5'h04;
    localparam logic [4:0] OP_SLL  = 5'h05;
    localparam logic [4:0] OP_SRL  = 5'h06;
    localparam logic [4:0] OP_AND  = 5'h07;
    localparam logic [4:0] OP_OR   = 5'h08;
    localparam logic [4:0] OP_XOR  = 5'h09;
    localparam logic [4:0] OP_CL   = 5'h0A;
    localparam logic [4:0] OP_CG   = 5'h0B;
    localparam logic [4:0] OP_CE   = 5'h0C;
    localparam logic [4:0] OP_ADC  = 5'h0D;
    localparam logic [4:0] OP_SBB  = 5'h0E;
    localparam logic [4:0] OP_NOTF = 5'h10;
    localparam logic [4:0] OP_MUL  = 5'h11;
    localparam logic [4:0] OP_DIV  = 5'h12;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] ext_q, ext_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;     // multiplicand / divisor latched at issue
    logic             carry_q, carry_d;
    logic             flag_q, flag_d;
    logic             is_div_q, is_div_d;
    logic             div0_q, div0_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH:0]   add_sum;
    logic [WIDTH:0]   sub_diff;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   rem_diff;
    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] step_ext;
    logic             load_ok;

    // Adder/subtractor and one iteration of the shift-add / restoring-divide step.
    always_comb begin
        add_sum   = {1'b0, acc_q} + {1'b0, bus.operand}
                  + {{WIDTH{1'b0}}, carry_q & (bus.opcode == OP_ADC)};
        sub_diff  = {1'b0, acc_q} - {1'b0, bus.operand}
                  - {{WIDTH{1'b0}}, carry_q & (bus.opcode == OP_SBB)};
        mul_sum   = {1'b0, ext_q} + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        rem_shift = {ext_q, acc_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, opnd_q};
        step_acc  = {mul_sum[0], acc_q[WIDTH-1:1]};
        step_ext  = mul_sum[WIDTH:1];
        if (is_div_q) begin
            if (!rem_diff[WIDTH]) begin
                step_ext = rem_diff[WIDTH-1:0];
                step_acc = {acc_q[WIDTH-2:0], 1'b1};
            end else begin
                step_ext = rem_shift[WIDTH-1:0];
                step_acc = {acc_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    // Next-state logic: single-cycle ops and loads in IDLE, MUL/DIV iteration in RUN.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        ext_d    = ext_q;
        opnd_d   = opnd_q;
        carry_d  = carry_q;
        flag_d   = flag_q;
        is_div_d = is_div_q;
        div0_d   = div0_q;
        cnt_d    = cnt_q;
        load_ok  = 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.valid) begin
                    case (bus.opcode)
                        OP_ADD, OP_ADC: begin
                            {carry_d, acc_d} = add_sum;
                            load_ok = 1'b0;
                        end
                        OP_SUB, OP_SBB: begin
                            acc_d   = sub_diff[WIDTH-1:0];
                            carry_d = sub_diff[WIDTH];
                            load_ok = 1'b0;
                        end
                        // Shift by the full operand; amounts >= WIDTH flush or sign-fill.
                        OP_SLA, OP_SLL: begin
                            acc_d   = acc_q << bus.operand;
                            carry_d = 1'b0;
                            load_ok = 1'b0;
                        end
                        OP_SRA: begin
                            acc_d   = WIDTH'($signed(acc_q) >>> bus.operand);
                            carry_d = 1'b0;
                            load_ok = 1'b0;
                        end
                        OP_SRL: begin
                            acc_d   = acc_q >> bus.operand;
                            carry_d = 1'b0;
                            load_ok = 1'b0;
                        end
                        OP_AND: begin
                            acc_d   = acc_q & bus.operand;
                            carry_d = 1'b0;
                            load_ok = 1'b0;
                        end
                        OP_OR: begin
                            acc_d   = acc_q | bus.operand;
                            carry_d = 1'b0;
                            load_ok = 1'b0;
                        end
                        OP_XOR: begin
                            acc_d   = acc_q ^ bus.operand;
                            carry_d = 1'b0;
                            load_ok = 1'b0;
                        end
                        OP_CL:   flag_d = $signed(acc_q) < $signed(bus.operand);
                        OP_CG:   flag_d = $signed(acc_q) > $signed(bus.operand);
                        OP_CE:   flag_d = (acc_q == bus.operand);
                        OP_NOTF: flag_d = ~flag_q;
                        OP_MUL, OP_DIV: begin
                            state_d  = ST_RUN;
                            cnt_d    = CW'(WIDTH);
                            opnd_d   = bus.operand;
                            is_div_d = (bus.opcode == OP_DIV);
                            div0_d   = (bus.operand == '0);
                            ext_d    = '0;
                            load_ok  = 1'b0;
                        end
                        default: ;
                    endcase
                end
                if (load_ok) begin
                    if (bus.write) begin
                        acc_d = bus.operand;
                    end
                    if (bus.writeu) begin
                        acc_d[WIDTH-1 -: UPPER_BITS] = bus.operand[UPPER_BITS-1:0];
                    end
                end
            end
            ST_RUN: begin
                cnt_d = cnt_q - CW'(1);
                acc_d = step_acc;
                ext_d = step_ext;
                if (cnt_q == CW'(1)) begin
                    state_d = ST_IDLE;
                    carry_d = 1'b0;
                    if (is_div_q) begin
                        flag_d = div0_q;
                        // Divisor zero never subtracts, so ext already holds the dividend.
                        if (div0_q) begin
                            acc_d = '1;
                        end
                    end else begin
                        flag_d = (step_ext != '0);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register with asynchronous reset that also aborts any MUL/DIV.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            ext_q    <= '0;
            opnd_q   <= '0;
            carry_q  <= 1'b0;
            flag_q   <= 1'b0;
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            ext_q    <= ext_d;
            opnd_q   <= opnd_d;
            carry_q  <= carry_d;
            flag_q   <= flag_d;
            is_div_q <= is_div_d;
            div0_q   <= div0_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.ext   = ext_q;
    assign bus.carry = carry_q;
    assign bus.flag  = flag_q;
    assign bus.busy  = (state_q == ST_RUN);
    assign accout    = bus.read ? acc_q : {WIDTH{1'bz}};
endmodule

// File: tb/tb_alu_mdu.sv
// Randomized self-checking bench for alu_mdu (WIDTH=16, UPPER_BITS=4) against
// an arithmetic reference model of the accumulator, extension and flags.
module tb_alu_mdu;
    localparam int W = 16;

    logic         clk;
    logic         rst;
    wire  [W-1:0] accout;

    alu_mdu_if #(.WIDTH(W)) bus_if ();

    alu_mdu #(.WIDTH(W), .UPPER_BITS(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus_if.slave),
        .accout (accout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state
    int m_acc   = 0;
    int m_ext   = 0;
    int m_carry = 0;
    int m_flag  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int sx(input int v);
        return (v >= 32768) ? v - 65536 : v;
    endfunction

    task automatic model(input logic [4:0] op, input int a, input bit w, input bit wu);
        bit     acc_wr;
        int     t;
        longint p;
        acc_wr = 1'b1;
        case (op)
            5'h01, 5'h0D: begin
                t = m_acc + a + ((op == 5'h0D) ? m_carry : 0);
                m_carry = (t >= 65536) ? 1 : 0;
                m_acc = t % 65536;
            end
            5'h02, 5'h0E: begin
                t = m_acc - a - ((op == 5'h0E) ? m_carry : 0);
                m_carry = (t < 0) ? 1 : 0;
                m_acc = (t < 0) ? t + 65536 : t;
            end
            5'h03, 5'h05: begin
                m_acc = (a >= 16) ? 0 : (m_acc * (1 << a)) % 65536;
                m_carry = 0;
            end
            5'h04: begin
                if (a >= 16) m_acc = (m_acc >= 32768) ? 65535 : 0;
                else m_acc = (sx(m_acc) >>> a) & 65535;
                m_carry = 0;
            end
            5'h06: begin
                m_acc = (a >= 16) ? 0 : m_acc / (1 << a);
                m_carry = 0;
            end
            5'h07: begin m_acc = m_acc & a; m_carry = 0; end
            5'h08: begin m_acc = m_acc | a; m_carry = 0; end
            5'h09: begin m_acc = m_acc ^ a; m_carry = 0; end
            5'h11: begin
                p = longint'(m_acc) * longint'(a);
                m_ext = int'(p / 65536);
                m_acc = int'(p % 65536);
                m_flag = (m_ext != 0) ? 1 : 0;
                m_carry = 0;
            end
            5'h12: begin
                if (a == 0) begin
                    m_ext = m_acc;
                    m_acc = 65535;
                    m_flag = 1;
                end else begin
                    m_ext = m_acc % a;
                    m_acc = m_acc / a;
                    m_flag = 0;
                end
                m_carry = 0;
            end
            default: begin
                acc_wr = 1'b0;
                if (op == 5'h0A) m_flag = (sx(m_acc) < sx(a)) ? 1 : 0;
                if (op == 5'h0B) m_flag = (sx(m_acc) > sx(a)) ? 1 : 0;
                if (op == 5'h0C) m_flag = (m_acc == a) ? 1 : 0;
                if (op == 5'h10) m_flag = 1 - m_flag;
            end
        endcase
        if (!acc_wr) begin
            if (w)  m_acc = a;
            if (wu) m_acc = (m_acc % 4096) + (a % 16) * 4096;
        end
    endtask

    task automatic clear_inputs();
        bus_if.valid  = 1'b0;
        bus_if.write  = 1'b0;
        bus_if.writeu = 1'b0;
        bus_if.opcode = 5'h00;
    endtask

    // Issue one op (with optional loads) and check the complete result.
    task automatic issue(input logic [4:0] op, input logic [15:0] opnd, input bit w, input bit wu);
        int n;
        bus_if.opcode  = op;
        bus_if.valid   = 1'b1;
        bus_if.operand = opnd;
        bus_if.write   = w;
        bus_if.writeu  = wu;
        @(posedge clk);
        #1;
        clear_inputs();
        model(op, int'(opnd), w, wu);
        if (op == 5'h11 || op == 5'h12) begin
            check("busy_rise", 32'(bus_if.busy), 32'd1);
            n = 0;
            while (bus_if.busy && n < 40) begin
                // Junk traffic while busy must be dropped.
                bus_if.valid   = 1'($urandom_range(0, 1));
                bus_if.opcode  = 5'($urandom_range(0, 31));
                bus_if.write   = 1'($urandom_range(0, 1));
                bus_if.writeu  = 1'($urandom_range(0, 1));
                bus_if.operand = 16'($urandom_range(0, 65535));
                @(posedge clk);
                #1;
                clear_inputs();
                n++;
            end
            check("busy_len", 32'(n), 32'd16);
        end
        check("acc", 32'(accout), 32'(m_acc));
        check("ext", 32'(bus_if.ext), 32'(m_ext));
        check("carry", 32'(bus_if.carry), 32'(m_carry));
        check("flag", 32'(bus_if.flag), 32'(m_flag));
        check("busy_idle", 32'(bus_if.busy), 32'd0);
        $display("op %02h opnd %04h w %0d wu %0d -> acc %04h ext %04h c %0d f %0d",
                 op, opnd, w, wu, accout, bus_if.ext, bus_if.carry, bus_if.flag);
    endtask

    task automatic load(input logic [15:0] v);
        issue(5'h00, v, 1'b1, 1'b0);
    endtask

    initial begin
        logic [4:0]  op;
        logic [15:0] opnd;
        rst = 1'b1;
        bus_if.read = 1'b1;
        bus_if.operand = '0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_acc", 32'(accout), 32'd0);
        check("rst_ext", 32'(bus_if.ext), 32'd0);
        check("rst_carry", 32'(bus_if.carry), 32'd0);
        check("rst_flag", 32'(bus_if.flag), 32'd0);
        check("rst_busy", 32'(bus_if.busy), 32'd0);

        // Add/sub chain
        load(16'hFFFF);
        issue(5'h01, 16'h0001, 1'b0, 1'b0);
        check("plan_add", {15'd0, bus_if.carry, accout}, 32'h0001_0000);
        issue(5'h0D, 16'h0000, 1'b0, 1'b0);
        check("plan_adc", {15'd0, bus_if.carry, accout}, 32'h0000_0001);
        issue(5'h02, 16'h0002, 1'b0, 1'b0);
        check("plan_sub", {15'd0, bus_if.carry, accout}, 32'h0001_FFFF);

        // Multiply with a load attempted while busy
        load(16'h1234);
        issue(5'h11, 16'h0100, 1'b0, 1'b0);
        check("plan_mul", {bus_if.ext, accout}, 32'h0012_3400);
        check("plan_mul_flag", 32'(bus_if.flag), 32'd1);

        // Divide and divide by zero
        load(16'h0064);
        issue(5'h12, 16'h0007, 1'b0, 1'b0);
        check("plan_div", {bus_if.ext, accout}, 32'h0002_000E);
        load(16'h0064);
        issue(5'h12, 16'h0000, 1'b0, 1'b0);
        check("plan_div0", {bus_if.ext, accout}, 32'h0064_FFFF);
        check("plan_div0_flag", 32'(bus_if.flag), 32'd1);

        // Compares and NOTF
        load(16'h8000);
        issue(5'h0A, 16'h0001, 1'b0, 1'b0);
        issue(5'h0B, 16'h0001, 1'b0, 1'b0);
        issue(5'h10, 16'h0000, 1'b0, 1'b0);
        load(16'h7FFF);
        issue(5'h0C, 16'h7FFF, 1'b0, 1'b0);

        // Shifts and loads
        load(16'h8000);
        issue(5'h04, 16'h0014, 1'b0, 1'b0);
        check("plan_sra", 32'(accout), 32'h0000_FFFF);
        load(16'h8000);
        issue(5'h06, 16'h0010, 1'b0, 1'b0);
        issue(5'h00, 16'h1234, 1'b1, 1'b1);
        check("plan_wwu", 32'(accout), 32'h0000_4234);
        issue(5'h01, 16'h1111, 1'b1, 1'b1);

        // Random traffic
        for (int i = 0; i < 150; i++) begin
            op = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) opnd = 16'($urandom_range(0, 20));
            else opnd = 16'($urandom_range(0, 65535));
            issue(op, opnd, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of a multiply
        load(16'h1234);
        issue(5'h0C, 16'h1234, 1'b0, 1'b0);
        bus_if.opcode  = 5'h11;
        bus_if.valid   = 1'b1;
        bus_if.operand = 16'h0100;
        @(posedge clk);
        #1;
        clear_inputs();
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        #3;
        rst = 1'b1;
        #1;
        check("midrst_busy", 32'(bus_if.busy), 32'd0);
        check("midrst_acc", 32'(accout), 32'd0);
        check("midrst_flag", 32'(bus_if.flag), 32'd0);
        check("midrst_ext", 32'(bus_if.ext), 32'd0);
        #1;
        rst = 1'b0;
        m_acc = 0;
        m_ext = 0;
        m_carry = 0;
        m_flag = 0;
        issue(5'h01, 16'h0003, 1'b0, 1'b0);
        check("post_rst_add", 32'(accout), 32'd3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
